// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_pkg
//  Description : Shared definitions for the 1010-preamble serial framing
//                (transmitter and pattern detector).
//  Contents    : tx_state_e state enum, PREAMBLE bit pattern, TRAIL_LEN.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    DATA  = 2'd2,
    TRAIL = 2'd3
  } tx_state_e;

  // Sent MSB first: 1, 0, 1, 0.
  localparam logic [3:0] PREAMBLE  = 4'b1010;
  localparam int         TRAIL_LEN = 2;

endpackage
`default_nettype wire

// File: rtl/pattern_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_frame_tx
//  Description : Serial frame transmitter. Accepts a parallel word on a
//                valid/ready handshake and sends preamble 1010, the payload
//                MSB first and a 00 trailer, one bit per clock. A 1 is
//                stuffed in DATA/TRAIL whenever the line would otherwise
//                form 1010, so the preamble is the only 1010 in a frame.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                tx_data        - payload word, sampled at acceptance
//                tx_valid       - payload word available
//                tx_ready       - word can be accepted (IDLE only)
//                out            - registered serial line, idles at 0
//                busy           - frame in progress
//                frame_count    - completed frames, wraps mod 2^32
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              out,
  output logic              busy,
  output logic [31:0]       frame_count
);

  localparam int              IDX_W     = $clog2(DATA_W) + 1;
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(3);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] TRAIL_END = IDX_W'(TRAIL_LEN);

  // r_state/r_idx name the segment and position of the next bit due on the
  // line; r_out holds the bit currently being driven.
  tx_state_e         r_state, w_state;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic [DATA_W-1:0] r_shreg, w_shreg;
  logic [2:0]        r_hist;
  logic              r_out, w_out;
  logic [31:0]       r_count, w_count;
  logic              w_due_zero;
  logic              w_stuff;

  // The trailer is all zeros; in DATA the due bit is the shift-register MSB.
  assign w_due_zero = (r_state == DATA) ? ~r_shreg[DATA_W-1] : 1'b1;
  // r_hist already includes the bit on the line, so 101 plus a due 0 would
  // complete 1010.
  assign w_stuff    = (r_hist == 3'b101) && w_due_zero;

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_shreg = r_shreg;
    w_out   = 1'b0;
    w_count = r_count;
    case (r_state)
      IDLE: begin
        if (tx_valid) begin
          w_state = PRE;
          w_idx   = IDX_W'(1);
          w_shreg = tx_data;
          w_out   = PREAMBLE[3];
        end
      end
      PRE: begin
        w_out = PREAMBLE[2'd3 - r_idx[1:0]];
        if (r_idx == PRE_LAST) begin
          w_state = DATA;
          w_idx   = '0;
        end else begin
          w_idx = r_idx + IDX_W'(1);
        end
      end
      DATA: begin
        if (w_stuff) begin
          // Position held: the due 0 goes out next cycle.
          w_out = 1'b1;
        end else begin
          w_out   = r_shreg[DATA_W-1];
          w_shreg = {r_shreg[DATA_W-2:0], 1'b0};
          if (r_idx == DATA_LAST) begin
            w_state = TRAIL;
            w_idx   = '0;
          end else begin
            w_idx = r_idx + IDX_W'(1);
          end
        end
      end
      TRAIL: begin
        if (r_idx == TRAIL_END) begin
          // Last trailer bit is ending: close the frame on this edge.
          w_state = IDLE;
          w_idx   = '0;
          w_count = r_count + 32'd1;
        end else if (w_stuff) begin
          w_out = 1'b1;
        end else begin
          w_out = 1'b0;
          w_idx = r_idx + IDX_W'(1);
        end
      end
      default: begin
        w_state = IDLE;
        w_idx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_shreg <= '0;
      r_hist  <= 3'b000;
      r_out   <= 1'b0;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_shreg <= w_shreg;
      r_hist  <= {r_hist[1:0], w_out};
      r_out   <= w_out;
      r_count <= w_count;
    end
  end

  assign tx_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign out         = r_out;
  assign frame_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pattern_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_frame_tx
//  Description : Directed self-checking bench for pattern_frame_tx with a
//                behavioural 1010 detector on the serial line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_frame_tx;

  logic        clk;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        out;
  logic        busy;
  logic [31:0] frame_count;

  int n_checks;
  int n_errors;

  // Behavioural downstream detector: counts 1010, overlaps included.
  logic [2:0]  det_sr;
  logic [31:0] det_cnt;

  pattern_frame_tx #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .out         (out),
    .busy        (busy),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      det_sr  <= 3'b000;
      det_cnt <= 32'd0;
    end else begin
      det_sr <= {det_sr[1:0], out};
      if ({det_sr, out} == 4'b1010) det_cnt <= det_cnt + 32'd1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one word and captures the serial bits while busy is high.
  // With mid_change set, tx_data is altered and tx_valid pulsed mid-frame.
  task automatic send(input logic [7:0] d, input bit mid_change,
                      output logic [63:0] bits, output int len);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    bits = '0;
    len  = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) tx_valid = 1'b0;
      if (!busy) break;
      bits = {bits[62:0], out};
      len++;
      if (mid_change && c == 2) begin
        tx_data  = ~d;
        tx_valid = 1'b1;
      end
      if (mid_change && c == 4) tx_valid = 1'b0;
    end
  endtask

  logic [63:0] bits;
  int          len;
  logic [31:0] det0;
  int          done;
  int          flen;
  int          ready_bad;
  int          len_bad;
  logic        busy_prev;
  int          cyc;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out",   {63'd0, out},         64'd0);
    check_val("rst_ready", {63'd0, tx_ready},    64'd1);
    check_val("rst_busy",  {63'd0, busy},        64'd0);
    check_val("rst_fc",    {32'd0, frame_count}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 8'hA5: three stuff bits.
    det0 = det_cnt;
    send(8'hA5, 1'b0, bits, len);
    check_val("a5_bits", bits, 64'(17'b1010_1101100101_100));
    check_val("a5_len",  64'(len), 64'd17);
    check_val("a5_det",  64'(det_cnt - det0), 64'd1);
    check_val("a5_fc",   {32'd0, frame_count}, 64'd1);
    check_val("a5_ready", {63'd0, tx_ready}, 64'd1);

    send(8'h00, 1'b0, bits, len);
    check_val("00_bits", bits, 64'(14'b1010_00000000_00));
    check_val("00_len",  64'(len), 64'd14);
    check_val("00_fc",   {32'd0, frame_count}, 64'd2);

    send(8'hFF, 1'b0, bits, len);
    check_val("ff_bits", bits, 64'(14'b1010_11111111_00));
    check_val("ff_len",  64'(len), 64'd14);

    det0 = det_cnt;
    send(8'h55, 1'b0, bits, len);
    check_val("55_bits", bits, 64'(17'b1010_0101_10_1_10_1_100));
    check_val("55_len",  64'(len), 64'd17);
    check_val("55_det",  64'(det_cnt - det0), 64'd1);

    // Payload change and valid pulses while busy.
    send(8'h3C, 1'b1, bits, len);
    check_val("mid_bits", bits, 64'(14'b1010_00111100_00));
    check_val("mid_len",  64'(len), 64'd14);
    repeat (4) @(negedge clk);
    check_val("mid_busy", {63'd0, busy}, 64'd0);
    check_val("mid_fc",   {32'd0, frame_count}, 64'd5);

    // Reset during the 6th bit of a frame.
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    check_val("pre_rst_out", {63'd0, out}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mrst_out",   {63'd0, out},         64'd0);
    check_val("mrst_ready", {63'd0, tx_ready},    64'd1);
    check_val("mrst_busy",  {63'd0, busy},        64'd0);
    check_val("mrst_fc",    {32'd0, frame_count}, 64'd0);
    repeat (3) @(negedge clk);
    check_val("mrst_quiet", {63'd0, out}, 64'd0);
    check_val("mrst_det",   {32'd0, det_cnt}, 64'd0);

    // Reset together with tx_valid: word must not be accepted.
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    @(negedge clk);
    check_val("rstv_busy", {63'd0, busy}, 64'd0);
    rst      = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check_val("rstv_idle", {63'd0, busy}, 64'd0);

    // 50 back-to-back frames, tx_valid held high.
    done      = 0;
    flen      = 0;
    ready_bad = 0;
    len_bad   = 0;
    busy_prev = 1'b0;
    tx_data   = 8'($urandom);
    tx_valid  = 1'b1;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (tx_ready !== ~busy) ready_bad++;
      if (busy) flen++;
      if (busy_prev && !busy) begin
        done++;
        if (flen < 14 || flen > 19) len_bad++;
        flen = 0;
      end
      // A frame may only start after a sampled idle cycle.
      if (!busy_prev && busy && flen != 1) len_bad++;
      busy_prev = busy;
      if (!busy) begin
        if (done == 50) begin
          tx_valid = 1'b0;
          break;
        end
        tx_data = 8'($urandom);
      end
    end
    check_val("rand_done",  64'(done), 64'd50);
    repeat (3) @(negedge clk);
    check_val("rand_fc",    {32'd0, frame_count}, 64'd50);
    check_val("rand_det",   {32'd0, det_cnt},     64'd50);
    check_val("rand_ready", 64'(ready_bad), 64'd0);
    check_val("rand_len",   64'(len_bad),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_frame_tx.md
# pattern_frame_tx

Serial frame transmitter that produces the bit stream our `1010` pattern detector consumes. It accepts a parallel word over a valid/ready handshake and emits one bit per clock: the preamble `1010`, the payload MSB-first, then a two-bit `00` trailer. It inserts stuff bits so that the detector matches exactly once per frame, on the preamble. The block sits upstream of the detector, and in the bench it drives the detector's serial input.

## Interface
- `DATA_W`, default 8: payload width in bits, ≥ 2.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_data`  in  DATA_W  payload word, sampled at acceptance.
- `tx_valid`  in  1  payload word available.
- `tx_ready`  out  1  block can accept a word (high only in IDLE).
- `out`  out  1  serial line, registered; idles at 0.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `frame_count`  out  32  number of completed frames, wraps modulo 2^32.

## Operation
- States:
  - IDLE → PRE on `tx_valid && tx_ready`.
  - PRE (4 bits) → DATA.
  - DATA (DATA_W payload bits plus any stuff bits) → TRAIL.
  - TRAIL (2 zero bits plus any stuff bits) → IDLE.
- At acceptance, latch `tx_data` into a shift register. Later changes on `tx_data` are ignored.
- `hist[2:0]` holds the last three values driven on `out`, newest in the LSB. It shifts every cycle, including IDLE.
- Stuff rule, DATA and TRAIL only:
  - If `hist == 3'b101` and the next bit due is 0, drive a 1 instead.
  - Do not advance the payload or trailer position; the due 0 follows in the next cycle.
  - PRE is never stuffed.
- After a stuff bit, `hist == 3'b011`, so two consecutive stuff bits cannot occur.
- Guaranteed result: the full stream (idle zeros plus frames) contains `1010` (overlapping matches included) exactly once per frame, at the preamble.
- `frame_count` increments on the edge that ends the last trailer bit.
- `tx_valid` while busy is ignored. Hold is the producer's responsibility (standard valid/ready).

## Timing
- Reset values: `out` = 0, `tx_ready` = 1, `busy` = 0, `frame_count` = 0, `hist` = 000, state = IDLE.
- Acceptance at edge k: `out` = 1 (first preamble bit) during the cycle after edge k; `tx_ready` is low from edge k.
- Frame length: 4 + DATA_W + 2 + S cycles, where S is the number of stuff bits.
  - Minimum is 14 cycles for DATA_W = 8.
  - S ≤ DATA_W/2 + 1.
- At the edge ending the final trailer bit, all of the following happen together: state → IDLE, `out` ← 0, `frame_count` + 1, `tx_ready` ← 1.
- There is at least one idle cycle between frames. A word can be accepted at the first IDLE edge.
- `rst` mid-frame: the frame is dropped, no count increment, and all outputs take their reset values at that edge. There are no partial bits after reset.
- `rst` together with `tx_valid`: reset wins and the word is not accepted.
- `frame_count` wraps from 0xFFFF_FFFF to 0.

## Structure
- Package `serial_frame_pkg` holds:
  - the state enum `tx_state_e` {IDLE, PRE, DATA, TRAIL};
  - `PREAMBLE = 4'b1010`;
  - `TRAIL_LEN = 2`.
- The detector and this block both import the package.
- Single module with no sub-module. Internals:
  - state register;
  - bit-index counter sized `$clog2(DATA_W)+1`;
  - payload shift register;
  - `hist`;
  - registered `out`.

## Test plan
- `tx_data` = 8'hA5, one frame → `out` = 1010 1101100101 100, 17 bits, S = 3 → detector counts 1, `frame_count` = 1.
- `tx_data` = 8'h00 → 1010 00000000 00, 14 bits, no stuffing. `tx_data` = 8'hFF → 1010 11111111 00, 14 bits.
- `tx_data` = 8'h55 → 1010 0101 10 1 10 1 100 (spaces for readability), 17 bits, S = 3 → exactly one detector match.
- 50 back-to-back frames with `$random` payloads and `tx_valid` held high → detector count = `frame_count` = 50. `tx_ready` is high only in IDLE, and there is at least one idle cycle between frames.
- Assert `rst` during the 6th bit of a frame → next cycle `out` = 0, `tx_ready` = 1, `busy` = 0, `frame_count` = 0. Detector counts 0 for the partial frame.
- Change `tx_data` mid-frame → emitted payload equals the value sampled at acceptance. `tx_valid` pulses while busy are not accepted.
